// File: rtl/combat_hp_ctrl.sv
// combat_hp_ctrl: player/boss hit points with saturating damage and heal,
// reloaded on GAME entry, with frame-timed invulnerability after accepted hits.
module combat_hp_ctrl #(
    parameter int PLAYER_MAX_HP  = 10,
    parameter int BOSS_MAX_HP    = 100,
    parameter int PLAYER_IFRAMES = 60,
    parameter int BOSS_IFRAMES   = 8,
    parameter int TMR_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic       frame_tick,
    input  logic       player_hit,
    input  logic [3:0] player_dmg,
    input  logic       boss_hit,
    input  logic [6:0] boss_dmg,
    input  logic       heal_pickup,
    output logic [3:0] current_health,
    output logic [6:0] boss_hp,
    output logic       player_invuln,
    output logic       boss_invuln
);
    localparam logic [3:0]       P_MAX = 4'(PLAYER_MAX_HP);
    localparam logic [6:0]       B_MAX = 7'(BOSS_MAX_HP);
    localparam logic [TMR_W-1:0] P_IF  = TMR_W'(PLAYER_IFRAMES);
    localparam logic [TMR_W-1:0] B_IF  = TMR_W'(BOSS_IFRAMES);
    localparam logic [TMR_W-1:0] ONE   = TMR_W'(1);

    logic [1:0]       prev_state;
    logic [TMR_W-1:0] p_cnt, b_cnt, p_cnt_nxt, b_cnt_nxt, p_dec, b_dec;
    logic [3:0]       hp_nxt, p_sub, p_heal;
    logic [6:0]       boss_nxt, b_sub;
    logic             entry, reload, active, p_acc, b_acc;

    always_comb begin
        entry     = game_state == 2'd1 && prev_state != 2'd1;
        reload    = game_state == 2'd0 || entry;
        // Outside MENU/GAME, and once anyone is dead, everything is frozen
        active    = game_state == 2'd1 && !entry && current_health != 4'd0 && boss_hp != 7'd0;
        p_acc     = player_hit && player_dmg != 4'd0 && p_cnt == '0;
        b_acc     = boss_hit && boss_dmg != 7'd0 && b_cnt == '0;
        p_sub     = (player_dmg >= current_health) ? 4'd0 : current_health - player_dmg;
        b_sub     = (boss_dmg >= boss_hp) ? 7'd0 : boss_hp - boss_dmg;
        p_heal    = (current_health < P_MAX) ? current_health + 4'd1 : current_health;
        p_dec     = (frame_tick && p_cnt != '0) ? p_cnt - ONE : p_cnt;
        b_dec     = (frame_tick && b_cnt != '0) ? b_cnt - ONE : b_cnt;
        hp_nxt    = reload ? P_MAX : !active ? current_health : p_acc ? p_sub : heal_pickup ? p_heal : current_health;
        boss_nxt  = reload ? B_MAX : !active ? boss_hp : b_acc ? b_sub : boss_hp;
        p_cnt_nxt = reload ? '0 : !active ? p_cnt : p_acc ? P_IF : p_dec;
        b_cnt_nxt = reload ? '0 : !active ? b_cnt : b_acc ? B_IF : b_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state     <= 2'd0;
            current_health <= P_MAX;
            boss_hp        <= B_MAX;
            p_cnt          <= '0;
            b_cnt          <= '0;
            player_invuln  <= 1'b0;
            boss_invuln    <= 1'b0;
        end else begin
            prev_state     <= game_state;
            current_health <= hp_nxt;
            boss_hp        <= boss_nxt;
            p_cnt          <= p_cnt_nxt;
            b_cnt          <= b_cnt_nxt;
            player_invuln  <= p_cnt_nxt != '0;
            boss_invuln    <= b_cnt_nxt != '0;
        end
    end
endmodule

// File: tb/tb_combat_hp_ctrl.sv
// tb_combat_hp_ctrl: directed test-plan sequences plus randomized traffic,
// checked every clock against an arithmetic model of the HP/invulnerability rules.
module tb_combat_hp_ctrl;
    localparam int PMAX = 10, BMAX = 100, PIF = 60, BIF = 8;

    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] game_state = 2'd0;
    logic       frame_tick = 1'b0, player_hit = 1'b0, boss_hit = 1'b0, heal_pickup = 1'b0;
    logic [3:0] player_dmg = '0;
    logic [6:0] boss_dmg = '0;
    logic [3:0] current_health;
    logic [6:0] boss_hp;
    logic       player_invuln, boss_invuln;

    int total = 0, bad = 0;
    int m_hp, m_boss, m_pt, m_bt, m_prev;

    combat_hp_ctrl dut (
        .clk(clk), .rst(rst), .game_state(game_state), .frame_tick(frame_tick),
        .player_hit(player_hit), .player_dmg(player_dmg), .boss_hit(boss_hit),
        .boss_dmg(boss_dmg), .heal_pickup(heal_pickup), .current_health(current_health),
        .boss_hp(boss_hp), .player_invuln(player_invuln), .boss_invuln(boss_invuln)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hp = PMAX; m_boss = BMAX; m_pt = 0; m_bt = 0; m_prev = 0;
    endtask

    // One clock of game rules, stated directly in terms of HP numbers and frame counts
    task automatic model_step();
        int gs, nhp, nboss, npt, nbt;
        bit pacc, bacc;
        gs = int'(game_state);
        nhp = m_hp; nboss = m_boss; npt = m_pt; nbt = m_bt;
        if (gs == 0 || (gs == 1 && m_prev != 1)) begin
            nhp = PMAX; nboss = BMAX; npt = 0; nbt = 0;
        end else if (gs == 1 && m_hp > 0 && m_boss > 0) begin
            pacc = player_hit && player_dmg != 0 && m_pt == 0;
            bacc = boss_hit && boss_dmg != 0 && m_bt == 0;
            if (frame_tick && npt > 0) npt--;
            if (frame_tick && nbt > 0) nbt--;
            if (pacc) begin
                nhp = m_hp - int'(player_dmg);
                if (nhp < 0) nhp = 0;
                npt = PIF;
            end else if (heal_pickup && m_hp + 1 <= PMAX) nhp = m_hp + 1;
            if (bacc) begin
                nboss = m_boss - int'(boss_dmg);
                if (nboss < 0) nboss = 0;
                nbt = BIF;
            end
        end
        m_hp = nhp; m_boss = nboss; m_pt = npt; m_bt = nbt; m_prev = gs;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check("hp", int'(current_health), m_hp);
        check("boss", int'(boss_hp), m_boss);
        check("p_inv", int'(player_invuln), int'(m_pt != 0));
        check("b_inv", int'(boss_invuln), int'(m_bt != 0));
    endtask

    task automatic step(input int gs, input bit ft, input bit ph, input int pd,
                        input bit bh, input int bd, input bit hl);
        game_state = 2'(gs); frame_tick = ft; player_hit = ph; player_dmg = 4'(pd);
        boss_hit = bh; boss_dmg = 7'(bd); heal_pickup = hl;
        tick();
        frame_tick = 0; player_hit = 0; boss_hit = 0; heal_pickup = 0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        check("rst_hp", int'(current_health), 10);
        check("rst_boss", int'(boss_hp), 100);
        rst = 0;
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 3, 0, 0, 0);
        check("entry_hit_ignored", int'(current_health), 10);
        check("entry_inv", int'(player_invuln), 0);
        step(1, 0, 1, 3, 0, 0, 0);
        check("hit3", int'(current_health), 7);
        check("hit3_inv", int'(player_invuln), 1);
        step(1, 0, 1, 3, 0, 0, 0);
        check("hit_in_iframes", int'(current_health), 7);
        frames(59);
        check("iframe_59", int'(player_invuln), 1);
        frames(1);
        check("iframe_60", int'(player_invuln), 0);
        step(1, 0, 1, 3, 0, 0, 0);
        check("hit_after_iframes", int'(current_health), 4);
        step(1, 0, 0, 0, 1, 95, 0);
        check("boss_95", int'(boss_hp), 5);
        frames(8);
        check("boss_iframes_done", int'(boss_invuln), 0);
        step(1, 0, 0, 0, 1, 20, 0);
        check("boss_no_wrap", int'(boss_hp), 0);
        step(1, 1, 1, 3, 0, 0, 1);
        check("frozen_hp", int'(current_health), 4);
        for (int i = 0; i < 100; i++)
            step(2, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 15),
                 $urandom_range(0, 1), $urandom_range(1, 127), $urandom_range(0, 1));
        check("end_hold_hp", int'(current_health), 4);
        check("end_hold_boss", int'(boss_hp), 0);

        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        frames(60);
        step(1, 0, 0, 0, 0, 0, 1);
        check("heal_9", int'(current_health), 10);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        check("heal_sat", int'(current_health), 10);
        step(1, 0, 1, 1, 0, 0, 0);
        frames(60);
        step(1, 0, 1, 2, 0, 0, 1);
        check("heal_hit", int'(current_health), 7);

        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        check("dmg0_hp", int'(current_health), 10);
        check("dmg0_inv", int'(player_invuln), 0);
        step(1, 0, 1, 1, 1, 1, 0);
        check("both_hp", int'(current_health), 9);
        check("both_boss", int'(boss_hp), 99);
        check("both_inv", int'({player_invuln, boss_invuln}), 3);
        frames(60);
        step(1, 0, 1, 5, 0, 0, 0);
        check("hp_4", int'(current_health), 4);
        rst = 1;
        #1;
        model_reset();
        check("async_rst", int'({current_health, boss_hp, player_invuln, boss_invuln}), {4'd10, 7'd100, 2'b00});
        tick();
        rst = 0;
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 15, 0, 0, 0);
        check("loss", int'(current_health), 0);
        step(2, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("reload_hp", int'(current_health), 10);
        check("reload_boss", int'(boss_hp), 100);

        begin
            int gs = 1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 49) == 0) gs = ($urandom_range(0, 9) < 6) ? 1 : $urandom_range(0, 3);
                if ($urandom_range(0, 999) == 0) rst = 1;
                step(gs, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
                     $urandom_range(0, 3) == 0,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 10),
                     $urandom_range(0, 4) == 0);
                rst = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/combat_hp_ctrl.md
Name: combat_hp_ctrl

Overview:
Owns the player and boss hit-point registers. It produces the current_health and boss_hp values that the game state machine monitors for its end-of-game condition, and it consumes that machine's game_state to decide when hits count and when HP reloads. Hit, damage and heal events from the collision and attack logic are applied here with saturating arithmetic. Per-entity invulnerability windows are timed in frames.

Parameters:
PLAYER_MAX_HP, 10, player HP loaded on reset and on GAME entry (1..15)
BOSS_MAX_HP, 100, boss HP loaded on reset and on GAME entry (1..127)
PLAYER_IFRAMES, 60, frame_tick count of player invulnerability after an accepted hit
BOSS_IFRAMES, 8, frame_tick count of boss invulnerability after an accepted hit
TMR_W, 8, width of the invulnerability counters (must hold both IFRAMES values)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
game_state  in  2  0=MENU, 1=GAME, 2=END_SCREEN, 3=unused (treated as not GAME)
frame_tick  in  1  one-clk pulse per video frame
player_hit  in  1  one-clk pulse, player struck
player_dmg  in  4  damage amount, sampled with player_hit
boss_hit  in  1  one-clk pulse, boss struck
boss_dmg  in  7  damage amount, sampled with boss_hit
heal_pickup  in  1  one-clk pulse, player +1 HP
current_health  out  4  registered player HP
boss_hp  out  7  registered boss HP
player_invuln  out  1  high while the player invulnerability counter is nonzero
boss_invuln  out  1  high while the boss invulnerability counter is nonzero

Behaviour:
- Reset (async): current_health=PLAYER_MAX_HP; boss_hp=BOSS_MAX_HP; both counters=0; both invuln outputs=0; prev_state=MENU.
- prev_state register holds game_state from the previous clk. GAME entry means game_state==1 && prev_state!=1.
- GAME entry cycle: reload both HPs to max and clear both counters. All hit and heal inputs in that cycle are ignored.
- MENU: HPs are held at max and counters are cleared every cycle.
- END_SCREEN and state 3: all registers frozen. No hits, heals or counter decrement.
- GAME, not the entry cycle, and both HPs nonzero:
  - Player hit is accepted iff player_hit && player_dmg!=0 && player counter==0.
    - On accept: current_health <= (player_dmg >= current_health) ? 0 : current_health-player_dmg.
    - On accept: player counter <= PLAYER_IFRAMES.
  - Boss hit is accepted iff boss_hit && boss_dmg!=0 && boss counter==0.
    - On accept: boss_hp <= (boss_dmg >= boss_hp) ? 0 : boss_hp-boss_dmg.
    - On accept: boss counter <= BOSS_IFRAMES.
  - Heal: if heal_pickup and no accepted player hit in the same cycle, current_health <= min(current_health+1, PLAYER_MAX_HP).
  - Heal coinciding with an accepted player hit is dropped; the hit wins.
  - Player and boss hits in the same cycle are independent and both apply.
  - Counters decrement by 1 on frame_tick when nonzero, and saturate at 0.
  - A decrement and a reload in the same cycle: reload wins.
- GAME with either HP ==0: both HPs and both counters are frozen. game_state leaves GAME on the next clk.
- Latency: every effect is visible on the outputs one clk after the triggering input edge.
- Invuln outputs: player_invuln = (player counter != 0), registered in the same cycle as the counter; boss_invuln likewise.
- Arithmetic: all subtraction is unsigned and compare-first, so HP never wraps. Heal never exceeds PLAYER_MAX_HP.
- Reset mid-GAME: immediate return to reset values. game_state then returns to MENU from its own reset.

Test Plan:
- Reset, then game_state MENU->GAME -> first GAME cycle holds current_health=10, boss_hp=100, invuln=0. A player_hit with dmg=3 pulsed in that entry cycle is ignored.
- GAME, player_hit dmg=3 -> next clk current_health=7 and player_invuln=1. A second hit dmg=3 before 60 frame_ticks leaves HP at 7. After 60 ticks player_invuln=0, and a further hit dmg=3 -> 4.
- GAME, boss_hp=5, boss_hit dmg=20 -> boss_hp=0, not wrapped. A later player_hit is ignored (HP frozen). Then game_state=END_SCREEN: values hold for 100 clks, including during heal and hit pulses.
- current_health=9, heal_pickup twice separated by 1 clk -> 10, then 10 (saturated). With current_health=9 and no hit cooldown, heal and hit dmg=2 in the same clk -> 7.
- current_health=10, player_hit dmg=0 -> HP stays 10 and player_invuln stays 0. Simultaneous player_hit dmg=1 and boss_hit dmg=1 -> next clk 9 and 99, both invuln=1.
- GAME with current_health=4: assert rst asynchronously mid-cycle -> outputs immediately read 10/100/0/0. END_SCREEN->MENU->GAME after a loss -> HP reloads to 10/100.
